// File: rtl/mc_pkg.sv
// Shared definitions for the macroblock sub-block scheduler: FSM state
// encoding, sub-block index width and the index-to-position decode.
package mc_pkg;

  localparam int BLK_IDX_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Column of a 4x4 sub-block inside the 16x16 macroblock (8x8-quadrant order)
  function automatic logic [1:0] blk_x_of(input logic [BLK_IDX_W-1:0] idx);
    return {idx[2], idx[0]};
  endfunction

  // Row of a 4x4 sub-block inside the 16x16 macroblock (8x8-quadrant order)
  function automatic logic [1:0] blk_y_of(input logic [BLK_IDX_W-1:0] idx);
    return {idx[3], idx[1]};
  endfunction

endpackage

// File: rtl/mc_sched_wdog.sv
// WAIT-state watchdog. Counts cycles while i_en is high and restarts from
// zero whenever i_en drops, so every entry into WAIT starts a fresh window.
// o_expired is asserted during the TIMEOUT-th consecutive enabled cycle.
module mc_sched_wdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_en,
  output logic o_expired
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_cnt;

  // Cycle counter: cleared outside WAIT, saturates at the limit inside it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (!i_en) begin
      r_cnt <= '0;
    end else if (r_cnt != LIMIT) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = i_en && (r_cnt == LIMIT);

endmodule

// File: rtl/mc_blk_sched.sv
// Macroblock sub-block scheduler. Accepts a macroblock command, then walks
// NUM_BLK 4x4 sub-blocks through the residual unit one at a time:
// ISSUE presents the source block, WAIT collects the residual once the
// downstream transform can take it, DONE reports completion.
// Optional build macro: MC_SCHED_TIMEOUT_EN adds a WAIT watchdog and the
// timeout_err output; without it WAIT may stall indefinitely.
module mc_blk_sched
  import mc_pkg::*;
#(
  parameter int NUM_BLK  = 16,
  parameter int ID_WIDTH = 8,
  parameter int TIMEOUT  = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 mb_start_valid,
  output logic                 mb_start_ready,
  input  logic [ID_WIDTH-1:0]  mb_id,
  output logic [BLK_IDX_W-1:0] blk_idx,
  output logic [1:0]           blk_x,
  output logic [1:0]           blk_y,
  output logic                 lc_src_valid,
  input  logic                 lc_src_ready,
  input  logic                 lc_dst_valid,
  output logic                 lc_dst_ready,
  input  logic                 down_ready,
  output logic                 res_wr_en,
  output logic [BLK_IDX_W-1:0] res_blk_idx,
  output logic                 mb_done,
  output logic [ID_WIDTH-1:0]  mb_done_id,
  output logic                 busy
`ifdef MC_SCHED_TIMEOUT_EN
  ,
  output logic                 timeout_err
`endif
);

  localparam logic [BLK_IDX_W-1:0] LAST_IDX = BLK_IDX_W'(NUM_BLK - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [BLK_IDX_W-1:0]  r_idx;
  logic [BLK_IDX_W-1:0]  w_idx_nxt;
  logic [ID_WIDTH-1:0]   r_id;
  logic [ID_WIDTH-1:0]   w_id_nxt;
  logic                  w_cmpl;
  logic                  w_wdog_exp;

  // A residual is taken only in WAIT; a sticky dst_valid elsewhere is ignored
  assign w_cmpl = (r_state == ST_WAIT) && lc_dst_valid && down_ready;

`ifdef MC_SCHED_TIMEOUT_EN
  mc_sched_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_en      (r_state == ST_WAIT),
    .o_expired (w_wdog_exp)
  );

  // A completion in the expiry cycle wins: the residual was already captured
  assign timeout_err = w_wdog_exp && !w_cmpl;
`else
  logic w_unused_timeout;
  assign w_wdog_exp       = 1'b0;
  assign w_unused_timeout = (TIMEOUT > 0) && w_wdog_exp;
`endif

  // State, sub-block index and latched tag registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_id    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_id    <= w_id_nxt;
    end
  end

  // Next-state logic for the command / issue / wait / done sequence
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_id_nxt    = r_id;
    case (r_state)
      ST_IDLE: begin
        if (mb_start_valid) begin
          w_id_nxt    = mb_id;
          w_idx_nxt   = '0;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (lc_src_ready) begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (w_cmpl) begin
          if (r_idx == LAST_IDX) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_idx_nxt   = r_idx + 1'b1;
            w_state_nxt = ST_ISSUE;
          end
        end else if (w_wdog_exp) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign mb_start_ready = (r_state == ST_IDLE);
  assign busy           = (r_state != ST_IDLE);
  assign lc_src_valid   = (r_state == ST_ISSUE);
  assign lc_dst_ready   = (r_state == ST_WAIT) && down_ready;
  assign res_wr_en      = w_cmpl;
  assign res_blk_idx    = r_idx;
  assign blk_idx        = r_idx;
  assign blk_x          = blk_x_of(r_idx);
  assign blk_y          = blk_y_of(r_idx);
  assign mb_done        = (r_state == ST_DONE);
  assign mb_done_id     = r_id;

endmodule

// File: doc/mc_blk_sched.md
MC_BLK_SCHED -- requirements
Module: mc_blk_sched

Interface
REQ-001 SHALL have parameter NUM_BLK, default 16: number of 4x4 sub-blocks per macroblock; must be a power of two, at most 16.
REQ-002 SHALL have parameter ID_WIDTH, default 8: bit-width of the macroblock tag.
REQ-003 SHALL have parameter TIMEOUT, default 64: watchdog limit in cycles; used only when MC_SCHED_TIMEOUT_EN is defined.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port mb_start_valid, input, 1 bit: new-macroblock command is valid.
REQ-007 SHALL have port mb_start_ready, output, 1 bit: scheduler accepts a command.
REQ-008 SHALL have port mb_id, input, ID_WIDTH bits: tag of the commanded macroblock.
REQ-009 SHALL have port blk_idx, output, 4 bits: sub-block decode index currently being issued.
REQ-010 SHALL have port blk_x, output, 2 bits: column of that sub-block within the 16x16 macroblock.
REQ-011 SHALL have port blk_y, output, 2 bits: row of that sub-block within the 16x16 macroblock.
REQ-012 SHALL have port lc_src_valid, output, 1 bit: drives the residual unit's source valid.
REQ-013 SHALL have port lc_src_ready, input, 1 bit: residual unit is ready for a source block.
REQ-014 SHALL have port lc_dst_valid, input, 1 bit: residual unit output is valid.
REQ-015 SHALL have port lc_dst_ready, output, 1 bit: drives the residual unit's destination ready.
REQ-016 SHALL have port down_ready, input, 1 bit: downstream transform stage can take a residual.
REQ-017 SHALL have port res_wr_en, output, 1 bit: one-cycle pulse; residual for res_blk_idx is captured.
REQ-018 SHALL have port res_blk_idx, output, 4 bits: index of the captured residual.
REQ-019 SHALL have port mb_done, output, 1 bit: one-cycle pulse at macroblock completion.
REQ-020 SHALL have port mb_done_id, output, ID_WIDTH bits: tag of the completed macroblock.
REQ-021 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-022 SHALL implement the states IDLE, ISSUE, WAIT and DONE.
REQ-023 IDLE: mb_start_ready=1; on mb_start_valid, latch mb_id, clear blk_idx to 0 and go to ISSUE.
REQ-024 mb_start_ready SHALL be 0 in every state other than IDLE; commands offered then are not consumed.
REQ-025 ISSUE: lc_src_valid=1, held until lc_src_ready=1; on that handshake, go to WAIT.
REQ-026 WAIT: lc_src_valid=0 and lc_dst_ready=down_ready; in every other state lc_dst_ready=0.
REQ-027 WAIT completion: when lc_dst_valid=1 and down_ready=1 in the same cycle, res_wr_en SHALL pulse for one cycle and res_blk_idx SHALL equal blk_idx.
REQ-028 After a completion, the state SHALL go to DONE if blk_idx==NUM_BLK-1; otherwise blk_idx increments and the state returns to ISSUE.
REQ-029 lc_dst_valid SHALL be ignored outside WAIT, since a residual unit may hold dst_valid high.
REQ-030 DONE: mb_done=1 and mb_done_id=latched tag for exactly one cycle, then go to IDLE.
REQ-031 blk_x SHALL be {blk_idx[2],blk_idx[0]} and blk_y SHALL be {blk_idx[3],blk_idx[1]} (H.264 8x8-quadrant decode order); both are combinational from blk_idx.
REQ-032 Issue latency: lc_src_valid SHALL rise the cycle after the start handshake; per-block minimum is 2 cycles.
REQ-033 down_ready=0 in WAIT: the scheduler SHALL stall indefinitely, holding blk_idx, unless the watchdog is enabled.

Reset
REQ-034 reset_n low SHALL force IDLE, blk_idx=0, res_blk_idx=0, mb_done_id=0, and lc_src_valid=lc_dst_ready=res_wr_en=mb_done=busy=0, with mb_start_ready=1 immediately.
REQ-035 Reset asserted mid-macroblock SHALL abandon it with no mb_done; release SHALL resume in IDLE.

Configuration
REQ-036 With MC_SCHED_TIMEOUT_EN defined, a watchdog SHALL count cycles spent in WAIT, clearing on entry to WAIT.
REQ-037 If the watchdog reaches TIMEOUT, the scheduler SHALL pulse an extra output port timeout_err (1 bit) for one cycle and go to IDLE without mb_done.
REQ-038 Without MC_SCHED_TIMEOUT_EN, the timeout_err port and the counter SHALL be absent, and WAIT has no bound.

Structure
REQ-039 Shared package mc_pkg SHALL hold the state enum, BLK_IDX_W=4, and the function mapping blk_idx to blk_x/blk_y.
REQ-040 The watchdog SHALL be the sub-module mc_sched_wdog, instantiated only under the macro.

Verification
REQ-041 Single MB: start with mb_id=8'h5A, residual unit always ready -> 16 res_wr_en pulses with idx 0..15, (blk_x,blk_y) of idx 5 = (3,0), then mb_done with id 8'h5A.
REQ-042 Backpressure: down_ready low for 10 cycles during idx 7 -> blk_idx held at 7, no res_wr_en, resumes at idx 8.
REQ-043 Back-to-back: mb_start_valid held high with id 1 then id 2 -> id 2 accepted only the cycle after the mb_done for id 1.
REQ-044 Sticky dst_valid: lc_dst_valid held high through ISSUE -> no res_wr_en until WAIT is entered.
REQ-045 Reset at idx 9 -> all outputs reach their reset values asynchronously; no mb_done; a new start runs from idx 0.
REQ-046 With macro, TIMEOUT=64 and lc_dst_valid stuck low -> timeout_err pulses at WAIT cycle 64; the state returns to IDLE.
